// File: rtl/fp_subtractor_pipe.sv
// fp_subtractor_pipe: 4-stage IEEE-754 single-precision subtractor, out = a - b.
// Ports: clk, rst_n (async, active-low), in_valid/in_ready + a, b (operands in),
//        out_valid/out_ready + result, flags {invalid, overflow, underflow} (out).
// Build option: define FP_SUB_RNE_EN for round-to-nearest-even, else truncate.
// Parameter FTZ: denormal inputs/outputs flushed to signed zero (1 only).
module fp_subtractor_pipe #(
    parameter int FTZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags
);

`ifdef FP_SUB_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic        spec;
        logic [31:0] spec_res;
        logic [2:0]  spec_flg;
        logic        sign;
        logic        sub;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [23:0] mx;
        logic [23:0] my;
    } s1_t;

    typedef struct packed {
        logic        spec;
        logic [31:0] spec_res;
        logic [2:0]  spec_flg;
        logic        sign;
        logic        sub;
        logic [7:0]  ex;
        logic [26:0] mx;
        logic [26:0] my;
    } s2_t;

    typedef struct packed {
        logic        spec;
        logic [31:0] spec_res;
        logic [2:0]  spec_flg;
        logic        sign;
        logic [7:0]  ex;
        logic [27:0] sum;
        logic [4:0]  lzc;
    } s3_t;

    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    logic        s3_valid_q, s3_valid_d;
    logic        out_valid_q, out_valid_d;
    s1_t         s1_q, s1_d;
    s2_t         s2_q, s2_d;
    s3_t         s3_q, s3_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  flags_q, flags_d;

    logic stall;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // ---------------- S1: unpack, specials, swap ----------------
    logic        sa, sb;
    logic [7:0]  ea, eb, ea_e, eb_e;
    logic [22:0] fa, fb;
    logic [23:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        b_gt;
    logic        spec;
    logic [31:0] spec_res;
    logic [2:0]  spec_flg;

    assign sa = a[31];
    assign sb = ~b[31];
    assign ea = a[30:23];
    assign eb = b[30:23];
    assign fa = a[22:0];
    assign fb = b[22:0];

    assign a_zero = (ea == 8'd0) && ((FTZ != 0) || (fa == 23'd0));
    assign b_zero = (eb == 8'd0) && ((FTZ != 0) || (fb == 23'd0));
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    assign ea_e = a_zero ? 8'd0 : ea;
    assign eb_e = b_zero ? 8'd0 : eb;
    assign ma   = a_zero ? 24'd0 : {ea != 8'd0, fa};
    assign mb   = b_zero ? 24'd0 : {eb != 8'd0, fb};
    assign b_gt = {eb_e, mb} > {ea_e, ma};

    always_comb begin
        spec     = 1'b1;
        spec_res = 32'd0;
        spec_flg = 3'b000;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
            spec_flg = 3'b100;
        end else if (a_inf && b_inf) begin
            // b already negated: differing signs mean Inf - Inf
            if (sa != sb) begin
                spec_res = QNAN;
                spec_flg = 3'b100;
            end else begin
                spec_res = {sa, 8'hFF, 23'd0};
            end
        end else if (a_inf) begin
            spec_res = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            spec_res = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            // only (-0) - (+0) keeps a negative sign
            spec_res = {sa & sb, 31'd0};
        end else begin
            spec = 1'b0;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (!stall) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.spec     = spec;
                s1_d.spec_res = spec_res;
                s1_d.spec_flg = spec_flg;
                s1_d.sub      = sa ^ sb;
                s1_d.sign     = b_gt ? sb : sa;
                s1_d.ex       = b_gt ? eb_e : ea_e;
                s1_d.ey       = b_gt ? ea_e : eb_e;
                s1_d.mx       = b_gt ? mb : ma;
                s1_d.my       = b_gt ? ma : mb;
            end
        end
    end

    // ---------------- S2: align ----------------
    logic [7:0]  d;
    logic [4:0]  sh;
    logic [53:0] wide;
    logic [26:0] my_al;

    assign d     = s1_q.ex - s1_q.ey;
    assign sh    = (d > 8'd27) ? 5'd27 : d[4:0];
    // low half of the wide vector catches every bit shifted out
    assign wide  = {s1_q.my, 3'b000, 27'd0} >> sh;
    assign my_al = {wide[53:28], wide[27] | (|wide[26:0])};

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (!stall) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.spec     = s1_q.spec;
                s2_d.spec_res = s1_q.spec_res;
                s2_d.spec_flg = s1_q.spec_flg;
                s2_d.sign     = s1_q.sign;
                s2_d.sub      = s1_q.sub;
                s2_d.ex       = s1_q.ex;
                s2_d.mx       = {s1_q.mx, 3'b000};
                s2_d.my       = my_al;
            end
        end
    end

    // ---------------- S3: add / subtract, LZC ----------------
    logic [27:0] sum;
    logic [4:0]  lzc;

    // X magnitude >= Y, so the difference never goes negative
    assign sum = s2_q.sub ? ({1'b0, s2_q.mx} - {1'b0, s2_q.my})
                          : ({1'b0, s2_q.mx} + {1'b0, s2_q.my});

    always_comb begin
        lzc = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (sum[i]) lzc = 5'(27 - i);
        end
    end

    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_d       = s3_q;
        if (!stall) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_d.spec     = s2_q.spec;
                s3_d.spec_res = s2_q.spec_res;
                s3_d.spec_flg = s2_q.spec_flg;
                s3_d.sign     = s2_q.sign;
                s3_d.ex       = s2_q.ex;
                s3_d.sum      = sum;
                s3_d.lzc      = lzc;
            end
        end
    end

    // ---------------- S4: normalize, round, pack ----------------
    logic [27:0]       norm;
    logic [22:0]       mant;
    logic              g, r, st, inc;
    logic [23:0]       mant_r;
    logic signed [9:0] exp_n, exp_r;
    logic [31:0]       pack_res;
    logic [2:0]        pack_flg;

    // Leading one lands on bit 27. A carry-out (lzc=0) is the
    // right-shift-by-one case; lzc>0 is the left-shift case.
    assign norm  = s3_q.sum << s3_q.lzc;
    assign mant  = norm[26:4];
    assign g     = norm[3];
    assign r     = norm[2];
    assign st    = |norm[1:0];
    assign inc   = RNE & g & (r | st | mant[0]);
    assign mant_r = {1'b0, mant} + {23'd0, inc};
    assign exp_n = $signed({2'b00, s3_q.ex}) + 10'sd1
                 - $signed({5'b00000, s3_q.lzc});
    // rounding carry from all-ones mantissa bumps the exponent
    assign exp_r = exp_n + $signed({9'd0, mant_r[23]});

    always_comb begin
        pack_res = {s3_q.sign, exp_r[7:0], mant_r[22:0]};
        pack_flg = 3'b000;
        if (!norm[27]) begin
            pack_res = 32'd0;
        end else if (exp_r >= 10'sd255) begin
            pack_res = {s3_q.sign, 8'hFF, 23'd0};
            pack_flg = 3'b010;
        end else if (exp_r <= 10'sd0) begin
            pack_res = {s3_q.sign, 31'd0};
            pack_flg = 3'b001;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (!stall) begin
            out_valid_d = s3_valid_q;
            if (s3_valid_q) begin
                result_d = s3_q.spec ? s3_q.spec_res : pack_res;
                flags_d  = s3_q.spec ? s3_q.spec_flg : pack_flg;
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            result_q    <= 32'd0;
            flags_q     <= 3'b000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s3_valid_q  <= s3_valid_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_subtractor_pipe.sv
// tb_fp_subtractor_pipe: directed bench for fp_subtractor_pipe.
// Streams, specials, rounding, backpressure and mid-flight reset.
module tb_fp_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FP_SUB_RNE_EN
    localparam logic [31:0] RND_EXP = 32'h3F80_0002;
`else
    localparam logic [31:0] RND_EXP = 32'h3F80_0001;
`endif

    fp_subtractor_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one isolated op: drive, accept, check latency and result
    task automatic run_one(input string tag, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] er,
                           input logic [2:0] ef);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_flags"}, {29'd0, flags}, {29'd0, ef});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        b         = 32'd0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, flags}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // stream: three back-to-back ops
        a = 32'h461C4000; b = 32'h45FA0000; in_valid = 1'b1;
        @(negedge clk);
        chk("st_lat1", {31'd0, out_valid}, 32'd0);
        a = 32'h44480000; b = 32'h44480000;
        @(negedge clk);
        chk("st_lat2", {31'd0, out_valid}, 32'd0);
        a = 32'h3F800000; b = 32'h3F000000;
        @(negedge clk);
        chk("st_lat3", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("st0_valid", {31'd0, out_valid}, 32'd1);
        chk("st0_res", result, 32'h44FA0000);
        chk("st0_flags", {29'd0, flags}, 32'd0);
        @(negedge clk);
        chk("st1_valid", {31'd0, out_valid}, 32'd1);
        chk("st1_res", result, 32'h00000000);
        @(negedge clk);
        chk("st2_valid", {31'd0, out_valid}, 32'd1);
        chk("st2_res", result, 32'h3F000000);
        @(negedge clk);
        chk("st_drain", {31'd0, out_valid}, 32'd0);

        // specials and corner values
        run_one("inf_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100);
        run_one("ovf", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3'b010);
        run_one("denorm", 32'h00400000, 32'h00000000, 32'h00000000, 3'b000);
        run_one("nz_pz", 32'h80000000, 32'h00000000, 32'h80000000, 3'b000);
        run_one("nan", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b100);
        run_one("inf_fin", 32'h7F800000, 32'h40A00000, 32'h7F800000, 3'b000);
        run_one("fin_inf", 32'h3F800000, 32'h7F800000, 32'hFF800000, 3'b000);
        run_one("swap", 32'h3F800000, 32'h40000000, 32'hBF800000, 3'b000);
        run_one("unf", 32'h00800000, 32'h00C00000, 32'h80000000, 3'b001);
        run_one("round", 32'h3F800000, 32'hB4400000, RND_EXP, 3'b000);

        // backpressure: 4 ops, consumer stalls 3 cycles
        @(negedge clk);
        a = 32'h461C4000; b = 32'h45FA0000; in_valid = 1'b1;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F000000;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000;
        @(negedge clk);
        a = 32'h44480000; b = 32'h44480000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_first_res", result, 32'h44FA0000);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready0", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_res", result, 32'h44FA0000);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_b_res", result, 32'h3F000000);
        @(negedge clk);
        chk("bp_c_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_c_res", result, 32'hBF800000);
        @(negedge clk);
        chk("bp_d_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_d_res", result, 32'h00000000);
        @(negedge clk);
        chk("bp_drain", {31'd0, out_valid}, 32'd0);

        // reset with ops in flight
        a = 32'h461C4000; b = 32'h45FA0000; in_valid = 1'b1;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F000000;
        @(negedge clk);
        a = 32'h7F800000; b = 32'h7F800000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mr_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_result", result, 32'd0);
        chk("mr_flags", {29'd0, flags}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mr_no_stale", {31'd0, out_valid}, 32'd0);
        end
        run_one("mr_next", 32'h3F800000, 32'h3F000000, 32'h3F000000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
